// File: rtl/fp_pkg.sv
// Shared constants for the FP adder output stage: field widths, special-value
// fields and the normaliser FSM state encoding.
package fp_pkg;

  localparam int FP_DATA_WIDTH = 32;
  localparam int FP_MENT_WIDTH = 23;
  localparam int FP_EXPO_WIDTH = 8;

  localparam logic [FP_EXPO_WIDTH-1:0] EXP_ALL_ONES = 8'hFF;
  localparam int                       EXP_BIAS     = 127;

  localparam logic [FP_MENT_WIDTH-1:0] FRAC_ZERO = 23'h0;
  localparam logic [FP_DATA_WIDTH-1:0] POS_INF   = 32'h7F80_0000;
  localparam logic [FP_DATA_WIDTH-1:0] ZERO      = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_NORM = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter over the {hidden, fraction} field; all-zero input
// returns WIDTH. Used only by the single-cycle normaliser build.
module fp_lzc
  import fp_pkg::*;
#(
  parameter int WIDTH = FP_MENT_WIDTH + 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] din,
  output logic [CNT_W-1:0] count
);

  logic found;

  always_comb begin
    count = CNT_W'(WIDTH);
    found = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!found && din[i]) begin
        count = CNT_W'(WIDTH - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_normalize_pack.sv
// Output stage of the FP adder: normalises the raw mantissa sum and packs a binary32
// word (truncating). Define FP_NORM_FAST_SHIFT_EN for a single-cycle LZC normaliser.
module fp_add_normalize_pack
  import fp_pkg::*;
#(
  parameter int DATA_WIDTH = FP_DATA_WIDTH,
  parameter int MENT_WIDTH = FP_MENT_WIDTH,
  parameter int EXPO_WIDTH = FP_EXPO_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [MENT_WIDTH+1:0]   sum_mant_in,
  input  logic [EXPO_WIDTH-1:0]   big_exp_in,
  input  logic                    sign_in,
  output logic                    valid_out,
  input  logic                    ready_in,
  output logic [DATA_WIDTH-1:0]   result_out,
  output logic                    overflow_out,
  output logic                    underflow_out
);

  // Exponent carries one spare bit so increment/decrement cannot wrap.
  localparam logic [EXPO_WIDTH:0] EXP_MAX = {1'b0, EXP_ALL_ONES};
  localparam logic [EXPO_WIDTH:0] EXP_ONE = (EXPO_WIDTH+1)'(1);

  logic [1:0]            state;
  logic [MENT_WIDTH+1:0] mant;
  logic [EXPO_WIDTH:0]   exp;
  logic                  sign;

  logic [MENT_WIDTH+1:0] mant_nx;
  logic [EXPO_WIDTH:0]   exp_nx;
  logic [EXPO_WIDTH:0]   exp_inc;
  logic                  resolve;
  logic [DATA_WIDTH-1:0] res_nx;
  logic                  ovf_nx;
  logic                  unf_nx;

  assign ready_out = (state == ST_IDLE) && !rst_in;
  assign valid_out = (state == ST_DONE);
  assign exp_inc   = exp + EXP_ONE;

`ifdef FP_NORM_FAST_SHIFT_EN
  localparam int LZC_W = $clog2(MENT_WIDTH + 2);

  logic [LZC_W-1:0]      lzc;
  logic [EXPO_WIDTH:0]   lzc_ext;
  logic [EXPO_WIDTH:0]   exp_m1;
  logic [EXPO_WIDTH-1:0] exp_dn;
  logic [MENT_WIDTH-1:0] frac_sh;

  fp_lzc #(.WIDTH(MENT_WIDTH + 1), .CNT_W(LZC_W)) u_lzc (
    .din   (mant[MENT_WIDTH:0]),
    .count (lzc)
  );

  assign lzc_ext = (EXPO_WIDTH+1)'(lzc);
  assign exp_m1  = (exp == '0) ? '0 : exp - EXP_ONE;
  assign exp_dn  = exp[EXPO_WIDTH-1:0] - EXPO_WIDTH'(lzc);
`endif

  always_comb begin
    mant_nx = mant;
    exp_nx  = exp;
    resolve = 1'b0;
    res_nx  = result_out;
    ovf_nx  = 1'b0;
    unf_nx  = 1'b0;
`ifdef FP_NORM_FAST_SHIFT_EN
    frac_sh = mant[MENT_WIDTH-1:0];
`endif
    if (exp == EXP_MAX) begin
      resolve = 1'b1;
      res_nx  = {sign, EXP_ALL_ONES, FRAC_ZERO};
    end else if (mant == '0) begin
      resolve = 1'b1;
      res_nx  = ZERO;
    end else if (mant[MENT_WIDTH+1]) begin
      resolve = 1'b1;
      if (exp_inc == EXP_MAX) begin
        res_nx = {sign, EXP_ALL_ONES, FRAC_ZERO};
        ovf_nx = 1'b1;
      end else begin
        res_nx = {sign, exp_inc[EXPO_WIDTH-1:0], mant[MENT_WIDTH:1]};
      end
    end else if (mant[MENT_WIDTH]) begin
      resolve = 1'b1;
      res_nx  = {sign, (exp == '0) ? EXPO_WIDTH'(1) : exp[EXPO_WIDTH-1:0],
                 mant[MENT_WIDTH-1:0]};
    end else begin
`ifdef FP_NORM_FAST_SHIFT_EN
      // Shift as far as the exponent allows; running out of exponent means denormal.
      resolve = 1'b1;
      if (lzc_ext <= exp_m1) begin
        frac_sh = mant[MENT_WIDTH-1:0] << lzc;
        res_nx  = {sign, exp_dn, frac_sh};
      end else begin
        frac_sh = mant[MENT_WIDTH-1:0] << exp_m1[LZC_W-1:0];
        res_nx  = {sign, {EXPO_WIDTH{1'b0}}, frac_sh};
        unf_nx  = |frac_sh;
      end
`else
      if (exp <= EXP_ONE) begin
        resolve = 1'b1;
        res_nx  = {sign, {EXPO_WIDTH{1'b0}}, mant[MENT_WIDTH-1:0]};
        unf_nx  = |mant[MENT_WIDTH-1:0];
      end else begin
        mant_nx = {mant[MENT_WIDTH:0], 1'b0};
        exp_nx  = exp - EXP_ONE;
      end
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= ST_IDLE;
      mant          <= '0;
      exp           <= '0;
      sign          <= 1'b0;
      result_out    <= ZERO;
      overflow_out  <= 1'b0;
      underflow_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_in) begin
            mant  <= sum_mant_in;
            exp   <= {1'b0, big_exp_in};
            sign  <= sign_in;
            state <= ST_NORM;
          end
        end
        ST_NORM: begin
          mant <= mant_nx;
          exp  <= exp_nx;
          if (resolve) begin
            result_out    <= res_nx;
            overflow_out  <= ovf_nx;
            underflow_out <= unf_nx;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ready_in) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_normalize_pack.sv
// Bench for fp_add_normalize_pack: directed vector table, random vectors against a
// closed-form normalisation model, plus backpressure and mid-operation reset.
module tb_fp_add_normalize_pack;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        ready_out;
  logic [24:0] sum_mant_in;
  logic [7:0]  big_exp_in;
  logic        sign_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result_out;
  logic        overflow_out;
  logic        underflow_out;

  int n_checks = 0;
  int n_fail   = 0;

  fp_add_normalize_pack dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .sum_mant_in   (sum_mant_in),
    .big_exp_in    (big_exp_in),
    .sign_in       (sign_in),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .result_out    (result_out),
    .overflow_out  (overflow_out),
    .underflow_out (underflow_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [24:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          k;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Value-level model: count the shifts needed to bring the leading one to the
  // hidden position, limited by how far the exponent can drop before denormal.
  function automatic void model(input logic [24:0] m, input logic [7:0] e, input logic s,
                                output logic [31:0] r, output logic ov, output logic un,
                                output int k);
    int p, need, avail, ne;
    logic [24:0] sm;
    k = 0; ov = 1'b0; un = 1'b0; r = '0;
    if (e == 8'd255) begin
      r = {s, 8'hFF, 23'h0};
    end else if (m == 25'd0) begin
      r = 32'h0;
    end else if (m[24]) begin
      ne = int'(e) + 1;
      if (ne == 255) begin
        r = {s, 8'hFF, 23'h0};
        ov = 1'b1;
      end else begin
        r = {s, 8'(ne), m[23:1]};
      end
    end else begin
      p = 0;
      for (int i = 0; i < 24; i++) if (m[i]) p = i;
      need  = 23 - p;
      avail = (e > 0) ? int'(e) - 1 : 0;
      if (need <= avail) begin
        ne = int'(e) - need;
        if (ne == 0) ne = 1;
        sm = m << need;
        r = {s, 8'(ne), sm[22:0]};
        k = need;
      end else begin
        sm = m << avail;
        r = {s, 8'h00, sm[22:0]};
        un = (sm[22:0] != 23'd0);
        k = avail;
      end
    end
  endfunction

  function automatic int exp_latency(input int k);
`ifdef FP_NORM_FAST_SHIFT_EN
    return 2;
`else
    return 2 + k;
`endif
  endfunction

  task automatic launch(input logic [24:0] m, input logic [7:0] e, input logic s);
    sum_mant_in = m;
    big_exp_in  = e;
    sign_in     = s;
    valid_in    = 1'b1;
    check("ready_before_accept", {31'd0, ready_out}, 32'd1);
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
  endtask

  // Counts cycles from the accept edge (counted as 1) until valid_out appears.
  task automatic wait_valid(output int n);
    n = 1;
    while (!valid_out && n < 40) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    if (!valid_out) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout actual=%0d cycles required=valid_out", n);
    end
  endtask

  task automatic run_vec(input string tag, input logic [24:0] m, input logic [7:0] e,
                         input logic s, input logic [31:0] r, input logic ov,
                         input logic un, input int k);
    int n;
    launch(m, e, s);
    wait_valid(n);
    check({tag, "_result"}, result_out, r);
    check({tag, "_ovf"}, {31'd0, overflow_out}, {31'd0, ov});
    check({tag, "_unf"}, {31'd0, underflow_out}, {31'd0, un});
    check({tag, "_latency"}, n, exp_latency(k));
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [24:0] m;
    logic [7:0]  e;
    logic        s;
    logic [31:0] r;
    logic        ov, un;
    int          k, n;

    vecs[0] = '{25'h1000000, 8'd127, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 0};
    vecs[1] = '{25'h0200000, 8'd127, 1'b0, 32'h3E80_0000, 1'b0, 1'b0, 2};
    vecs[2] = '{25'h0000000, 8'd127, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 0};
    vecs[3] = '{25'h1000000, 8'd254, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 0};
    vecs[4] = '{25'h0000001, 8'd3,   1'b0, 32'h0000_0004, 1'b0, 1'b1, 2};
    vecs[5] = '{25'h0800000, 8'd0,   1'b1, 32'h8080_0000, 1'b0, 1'b0, 0};
    vecs[6] = '{25'h0123456, 8'd255, 1'b1, 32'hFF80_0000, 1'b0, 1'b0, 0};
    vecs[7] = '{25'h1FFFFFF, 8'd10,  1'b0, 32'h05FF_FFFF, 1'b0, 1'b0, 0};
    vecs[8] = '{25'h0000001, 8'd127, 1'b0, 32'h3400_0000, 1'b0, 1'b0, 23};
    vecs[9] = '{25'h0400000, 8'd1,   1'b0, 32'h0040_0000, 1'b0, 1'b1, 0};

    rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
    sum_mant_in = '0; big_exp_in = '0; sign_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_ready_low", {31'd0, ready_out}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_result", result_out, 32'd0);
    check("rst_flags", {30'd0, overflow_out, underflow_out}, 32'd0);
    rst_in = 1'b0;
    #1;
    check("rst_ready_high", {31'd0, ready_out}, 32'd1);

    foreach (vecs[i])
      run_vec($sformatf("vec%0d", i), vecs[i].mant, vecs[i].exp, vecs[i].sign,
              vecs[i].res, vecs[i].ovf, vecs[i].unf, vecs[i].k);

    for (int t = 0; t < 60; t++) begin
      m = 25'($urandom) >> $urandom_range(0, 25);
      if ($urandom_range(0, 3) == 0) m[24] = 1'b1;
      e = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
      s = 1'($urandom);
      model(m, e, s, r, ov, un, k);
      run_vec($sformatf("rnd%0d", t), m, e, s, r, ov, un, k);
    end

    // Downstream stalls: result and flags must hold, no new accept.
    ready_in = 1'b0;
    launch(25'h1000000, 8'd254, 1'b0);
    wait_valid(n);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_in);
      #1;
      check("stall_valid", {31'd0, valid_out}, 32'd1);
      check("stall_result", result_out, 32'h7F80_0000);
      check("stall_ovf", {31'd0, overflow_out}, 32'd1);
      check("stall_ready", {31'd0, ready_out}, 32'd0);
    end
    ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    check("release_valid", {31'd0, valid_out}, 32'd0);
    check("release_ready", {31'd0, ready_out}, 32'd1);

    // Reset while normalising discards the in-flight sum.
    launch(25'h0000001, 8'd127, 1'b1);
    rst_in = 1'b1;
    #1;
    check("midrst_ready_low", {31'd0, ready_out}, 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    #1;
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    check("midrst_ready", {31'd0, ready_out}, 32'd1);
    check("midrst_result", result_out, 32'd0);
    check("midrst_flags", {30'd0, overflow_out, underflow_out}, 32'd0);
    repeat (30) begin
      @(posedge clk_in);
      #1;
      if (valid_out) begin
        n_fail++;
        $display("FAIL midrst_ghost actual=valid_out required=idle");
      end
    end
    n_checks++;

    run_vec("post_rst", 25'h0200000, 8'd127, 1'b0, 32'h3E80_0000, 1'b0, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
